// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel coordinates and lock from an incoming VGA-timed stream.
// Optional frame checksum is compiled in with VGA_RX_CHECKSUM_EN.
module vga_sync_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  output logic [9:0]  pxl_x,
  output logic [9:0]  pxl_y,
  output logic        pxl_valid,
  output logic [3:0]  red_out,
  output logic [3:0]  green_out,
  output logic [3:0]  blue_out,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] frame_sum,
  output logic        sum_valid
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  localparam logic [9:0]  HX0 = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  HX1 = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  VY0 = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VY1 = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] HT  = 11'(H_TOTAL);
  localparam logic [10:0] VT  = 11'(V_TOTAL);
  logic        hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic [11:0] rgb_q;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d, x_d, y_d;
  logic        armed_q, armed_d, bad_q, bad_d;
  logic        h_edge, v_edge, frame_ev, viol, valid_d;
  state_t      state_q, state_d;
  // Stage 1: capture syncs as "asserted" flags so the polarity never leaks further in.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= h_sync == SYNC_POL;
      hs_prev_q <= hs_q;
      vs_q      <= v_sync == SYNC_POL;
      vs_prev_q <= vs_q;
      rgb_q     <= {red_in, green_in, blue_in};
    end
  end
  always_comb begin
    h_edge   = hs_q & ~hs_prev_q;
    v_edge   = vs_q & ~vs_prev_q;
    frame_ev = h_edge & (armed_q | v_edge);
    armed_d  = ~frame_ev & (armed_q | v_edge);
    hcnt_d   = h_edge ? 10'd0 : (hcnt_q == 10'h3FF) ? hcnt_q : hcnt_q + 10'd1;
    vcnt_d   = frame_ev ? 10'd0 : (h_edge && vcnt_q != 10'h3FF) ? vcnt_q + 10'd1 : vcnt_q;
    viol     = (h_edge && {1'b0, hcnt_q} + 11'd1 != HT) ||
               (frame_ev && {1'b0, vcnt_q} + 11'd1 != VT) ||
               hcnt_d == 10'h3FF || vcnt_d == 10'h3FF;
  end
  always_ff @(posedge clk_25) begin
    if (reset) begin
      state_q <= SEARCH;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      armed_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      armed_q <= armed_d;
      bad_q   <= bad_d;
    end
  end
  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    unique case (state_q)
      SEARCH: if (frame_ev) begin
        state_d = ACQUIRE;
        bad_d   = 1'b0;
      end
      ACQUIRE: if (frame_ev) begin
        state_d = (bad_q | viol) ? ACQUIRE : LOCKED;
        bad_d   = 1'b0;
      end else bad_d = bad_q | viol;
      LOCKED: if (viol) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end
  always_comb begin
    valid_d = state_d == LOCKED && hcnt_d >= HX0 && hcnt_d < HX1 && vcnt_d >= VY0 && vcnt_d < VY1;
    x_d     = valid_d ? hcnt_d - HX0 : 10'd0;
    y_d     = valid_d ? vcnt_d - VY0 : 10'd0;
  end
  always_ff @(posedge clk_25) begin
    if (reset) begin
      pxl_valid   <= 1'b0;
      pxl_x       <= '0;
      pxl_y       <= '0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pxl_valid   <= valid_d;
      pxl_x       <= x_d;
      pxl_y       <= y_d;
      {red_out, green_out, blue_out} <= valid_d ? rgb_q : 12'h0;
      frame_start <= valid_d && x_d == 10'd0 && y_d == 10'd0;
      locked      <= state_d == LOCKED;
      sync_err    <= state_q == LOCKED && viol;
    end
  end
`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc_q, acc_d;
  logic        sum_ev;
  always_comb begin
    sum_ev = frame_ev && state_q == LOCKED && state_d == LOCKED;
    acc_d  = (state_d != LOCKED || frame_ev) ? 16'h0 : acc_q + (valid_d ? {4'h0, rgb_q} : 16'h0);
  end
  always_ff @(posedge clk_25) begin
    if (reset) begin
      acc_q     <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sum_valid <= sum_ev;
      if (sum_ev) frame_sum <= acc_q;
    end
  end
`else
  assign frame_sum = 16'h0;
  assign sum_valid = 1'b0;
`endif
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: scenario table plus per-sample reference model for vga_sync_receiver.
module tb_vga_sync_receiver;
  localparam int HT = 16, HS = 2, HB = 3, HA = 8, VS = 1, VB = 2, VA = 5, VT = 10;
  localparam bit POL = 1'b0;
`ifdef VGA_RX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic        clk_25 = 1'b0, reset = 1'b1, h_sync = ~POL, v_sync = ~POL;
  logic [3:0]  red_in = '0, green_in = '0, blue_in = '0;
  logic [9:0]  pxl_x, pxl_y;
  logic        pxl_valid, frame_start, locked, sync_err, sum_valid;
  logic [3:0]  red_out, green_out, blue_out;
  logic [15:0] frame_sum;
  always #20 clk_25 = ~clk_25;
  vga_sync_receiver #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT), .V_SYNC(VS), .V_BP(VB),
                      .V_ACTIVE(VA), .V_TOTAL(VT), .SYNC_POL(POL)) dut (
    .clk_25(clk_25), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pxl_x(pxl_x), .pxl_y(pxl_y), .pxl_valid(pxl_valid),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
    .frame_sum(frame_sum), .sum_valid(sum_valid));
  typedef struct packed {
    logic v; logic [9:0] x, y; logic [11:0] rgb; logic fs, lk, err, sv; logic [15:0] sum;
  } out_t;
  // nf frames; ve = early vsync; sf/sl = stretched line; rf/rl/rc = reset point; mode 0 random, 1 pattern, 2 white
  typedef struct {
    int nf; bit ve; int sf, sl, rf, rl, rc, mode, ev, efs, eerr, esv; logic [15:0] esum;
  } scen_t;
  scen_t       tbl[5];
  out_t        q[$];
  int          stage, cur_len, lines_seen, n_v, n_fs, n_err, n_sv, checks, passed;
  bit          bad;
  logic [15:0] acc, last_sum;
  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask
  task automatic observe();
    out_t a, e;
    a = {pxl_valid, pxl_x, pxl_y, red_out, green_out, blue_out, frame_start, locked, sync_err, sum_valid, frame_sum};
    n_v += int'(pxl_valid);
    n_fs += int'(frame_start);
    n_err += int'(sync_err);
    n_sv += int'(sum_valid);
    if (q.size() >= 2) begin
      e = q.pop_front();
      checks++;
      if (a === e) passed++;
      else $display("FAIL stream @%0t: got %h, want %h", $time, a, e);
    end
  endtask
  // Drive one sample at column hp of line vp and predict the output it produces two cycles later.
  task automatic step(input bit hs, input bit vs, input logic [11:0] c, input int hp, input int vp);
    bit ls, fe, viol, err, sv, val;
    logic [9:0] x, y;
    @(negedge clk_25);
    observe();
    h_sync = hs ? POL : ~POL;
    v_sync = vs ? POL : ~POL;
    {red_in, green_in, blue_in} = c;
    ls = hp == 0;
    fe = ls && vp == 0;
    viol = ls && (cur_len != HT || (fe && lines_seen != VT));
    if (ls) begin
      cur_len = 0;
      lines_seen = fe ? 1 : lines_seen + 1;
    end
    cur_len++;
    err = 1'b0;
    sv = 1'b0;
    if (stage == 2 && viol) begin
      stage = 0;
      err = 1'b1;
    end else if (fe) begin
      if (stage == 0) stage = 1;
      else if (stage == 1) stage = (bad || viol) ? 1 : 2;
      else begin
        sv = 1'b1;
        last_sum = acc;
      end
      bad = 1'b0;
    end else if (stage == 1) bad = bad | viol;
    if (stage != 2 || fe) acc = '0;
    val = stage == 2 && hp >= HS + HB && hp < HS + HB + HA && vp >= VS + VB && vp < VS + VB + VA;
    x = val ? 10'(hp - HS - HB) : 10'd0;
    y = val ? 10'(vp - VS - VB) : 10'd0;
    if (val) acc += {4'h0, c};
    q.push_back({val, x, y, val ? c : 12'h0, val && x == 0 && y == 0, stage == 2, err, sv & CK,
                 CK ? last_sum : 16'h0});
  endtask
  task automatic do_reset();
    @(negedge clk_25);
    observe();
    reset = 1'b1;
    h_sync = ~POL;
    v_sync = ~POL;
    q.delete();
    stage = 0;
    bad = 1'b0;
    acc = '0;
    last_sum = '0;
    @(negedge clk_25);
    checks++;
    if ({pxl_valid, pxl_x, pxl_y, red_out, green_out, blue_out, frame_start, locked, sync_err,
         sum_valid, frame_sum} === 53'h0) passed++;
    else $display("FAIL reset: outputs %h, want 0", {pxl_valid, pxl_x, pxl_y, red_out, green_out,
                  blue_out, frame_start, locked, sync_err, sum_valid, frame_sum});
    reset = 1'b0;
  endtask
  initial begin
    logic [11:0] col;
    logic [9:0]  px, py;
    checks = 0;
    passed = 0;
    cur_len = 0;
    lines_seen = 0;
    tbl[0] = '{3, 1'b0, -1, -1, -1, -1, -1, 1, 80, 2, 0, int'(CK), 16'h0};
    tbl[1] = '{3, 1'b1, -1, -1, -1, -1, -1, 0, 80, 2, 0, int'(CK), 16'h0};
    tbl[2] = '{5, 1'b0, 2, 4, -1, -1, -1, 0, 96, 3, 1, int'(CK), 16'h0};
    tbl[3] = '{5, 1'b0, -1, -1, 2, 5, 6, 0, 96, 3, 0, int'(CK), 16'h0};
    tbl[4] = '{4, 1'b0, -1, -1, -1, -1, -1, 2, 120, 3, 0, 2 * int'(CK), CK ? 16'h7FD8 : 16'h0};
    for (int s = 0; s < 5; s++) begin
      do_reset();
      n_v = 0;
      n_fs = 0;
      n_err = 0;
      n_sv = 0;
      for (int f = 0; f < tbl[s].nf; f++)
        for (int l = 0; l < VT; l++)
          for (int c = 0; c < ((f == tbl[s].sf && l == tbl[s].sl) ? HT + 1 : HT); c++) begin
            if (f == tbl[s].rf && l == tbl[s].rl && c == tbl[s].rc) do_reset();
            else begin
              px = 10'(c - HS - HB);
              py = 10'(l - VS - VB);
              col = tbl[s].mode == 2 ? 12'hFFF : tbl[s].mode == 1 ? {px[3:0], py[3:0], px[7:4]}
                                                                  : 12'($urandom);
              step(c < HS, l < VS || (tbl[s].ve && l == VT - 1 && f + 1 < tbl[s].nf && c >= 10),
                   col, c, l);
            end
          end
      check_int($sformatf("s%0d valid_count", s), n_v, tbl[s].ev);
      check_int($sformatf("s%0d frame_starts", s), n_fs, tbl[s].efs);
      check_int($sformatf("s%0d sync_errs", s), n_err, tbl[s].eerr);
      check_int($sformatf("s%0d sum_valids", s), n_sv, tbl[s].esv);
      if (tbl[s].mode == 2) check_int($sformatf("s%0d frame_sum", s), int'(frame_sum), int'(tbl[s].esum));
    end
    do_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
